// File: rtl/window_fetch_if.sv
// Bundles the hop input, image-memory read port and pixel output stream of window_fetch.
// master is the fetch block's view; slave is the surrounding environment's view.
interface window_fetch_if #(
    parameter int unsigned W_X    = 6,
    parameter int unsigned W_Y    = 6,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);

    logic              hop_valid;
    logic              hop_ready;
    logic [W_X-1:0]    x_hop;
    logic [W_Y-1:0]    y_hop;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;

    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              pix_eol;
    logic              pix_last;

    modport master (
        input  hop_valid,
        input  x_hop,
        input  y_hop,
        output hop_ready,
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output pix_valid,
        input  pix_ready,
        output pix_data,
        output pix_eol,
        output pix_last
    );

    modport slave (
        output hop_valid,
        output x_hop,
        output y_hop,
        input  hop_ready,
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  pix_valid,
        output pix_ready,
        input  pix_data,
        input  pix_eol,
        input  pix_last
    );

endinterface

// File: rtl/window_fetch.sv
// Fetches a SWEEP_X x SWEEP_Y pixel window per accepted hop from a 1-cycle-latency image memory
// and streams it row-major through a 2-entry credit-controlled output FIFO.
module window_fetch #(
    parameter int unsigned IMG_WIDTH  = 41,
    parameter int unsigned IMG_HEIGHT = 50,
    parameter int unsigned SWEEP_X    = 24,
    parameter int unsigned SWEEP_Y    = 24,
    parameter int unsigned DATA_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    window_fetch_if.master  bus,
    output logic            busy
);

    localparam int unsigned W_X    = $clog2(IMG_WIDTH);
    localparam int unsigned W_Y    = $clog2(IMG_HEIGHT);
    localparam int unsigned ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int unsigned W_COL  = (SWEEP_X > 1) ? $clog2(SWEEP_X) : 1;
    localparam int unsigned W_ROW  = (SWEEP_Y > 1) ? $clog2(SWEEP_Y + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [W_COL-1:0]    col_q, col_d;
    logic [W_ROW-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;

    logic                inflight_q;
    logic                tag_eol_q;
    logic                tag_last_q;

    logic [DATA_W-1:0]   fifo_data_q [2];
    logic                fifo_eol_q  [2];
    logic                fifo_last_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q, count_d;

    logic                push;
    logic                pop;
    logic                credit_ok;
    logic                issue_eol;
    logic                issue_last;
    logic                hop_accept;

    // Tags of the pixel currently being issued; they ride alongside inflight.
    assign issue_eol  = (col_q == W_COL'(SWEEP_X - 1));
    assign issue_last = issue_eol && (row_q == W_ROW'(SWEEP_Y - 1));

    assign push = inflight_q;
    assign pop  = bus.pix_valid && bus.pix_ready;

    // The memory cannot stall, so every issued read must already own a FIFO slot.
    assign credit_ok = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));

    assign bus.hop_ready = (state_q == StIdle) && !rst;
    assign hop_accept    = bus.hop_valid && bus.hop_ready;
    assign bus.mem_rd_en = (state_q == StFetch) && credit_ok && !rst;
    assign bus.mem_addr  = row_base_q + ADDR_W'(col_q);

    assign bus.pix_valid = (count_q != 2'd0);
    assign bus.pix_data  = fifo_data_q[rd_ptr_q];
    assign bus.pix_eol   = fifo_eol_q[rd_ptr_q];
    assign bus.pix_last  = fifo_last_q[rd_ptr_q];

    assign busy = (state_q != StIdle);

    assign count_d = count_q + 2'(push) - 2'(pop);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;

        case (state_q)
            StIdle: begin
                if (hop_accept) begin
                    state_d    = StFetch;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = ADDR_W'(bus.y_hop) * ADDR_W'(IMG_WIDTH) + ADDR_W'(bus.x_hop);
                end
            end

            StFetch: begin
                if (bus.mem_rd_en) begin
                    if (issue_eol) begin
                        col_d      = '0;
                        row_d      = row_q + 1'b1;
                        row_base_d = row_base_q + ADDR_W'(IMG_WIDTH);
                        if (issue_last) begin
                            state_d = StDrain;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            StDrain: begin
                // Leave as soon as the final pop empties the FIFO so a new hop lands next cycle.
                if ((count_d == 2'd0) && !inflight_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            inflight_q <= 1'b0;
            tag_eol_q  <= 1'b0;
            tag_last_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            inflight_q <= bus.mem_rd_en;
            tag_eol_q  <= issue_eol;
            tag_last_q <= issue_last;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Payload storage needs no reset: count_q alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.mem_rd_data;
            fifo_eol_q[wr_ptr_q]  <= tag_eol_q;
            fifo_last_q[wr_ptr_q] <= tag_last_q;
        end
    end

endmodule

// File: tb/tb_window_fetch.sv
// Scoreboard bench for window_fetch: expected addresses and pixels are queued on each accepted
// hop and retired as the memory port and pixel stream produce them.
module tb_window_fetch;

    localparam int unsigned IMG_WIDTH  = 41;
    localparam int unsigned IMG_HEIGHT = 50;
    localparam int unsigned SWEEP_X    = 24;
    localparam int unsigned SWEEP_Y    = 24;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned W_X        = $clog2(IMG_WIDTH);
    localparam int unsigned W_Y        = $clog2(IMG_HEIGHT);
    localparam int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int          NPIX       = SWEEP_X * SWEEP_Y;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   cyc = 0;

    window_fetch_if #(.W_X(W_X), .W_Y(W_Y), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    window_fetch #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .SWEEP_X   (SWEEP_X),
        .SWEEP_Y   (SWEEP_Y),
        .DATA_W    (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Image memory: data = addr[7:0], one cycle after the strobe; filler otherwise.
    always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? bus.mem_addr[7:0] : 8'hA5;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W+1:0] exp_pix  [$];

    int   acc_cnt        = 0;
    int   acc_cyc        = 0;
    int   acc_gap        = 0;
    int   first_rd_cyc   = -1;
    int   first_pv_cyc   = -1;
    int   last_hs_cyc    = -1000;
    int   ready_back_cyc = -1;
    int   win_pix        = 0;
    int   win_eol        = 0;
    int   win_reads      = 0;
    int   first_addr     = -1;
    int   max_addr       = 0;
    int   outstanding    = 0;
    bit   waiting_ready  = 1'b0;
    bit   prev_stall     = 1'b0;
    logic [DATA_W+1:0] prev_pix;

    // Monitor: scoreboard retirement, stall stability and read-credit bound.
    always @(negedge clk) begin
        logic [DATA_W+1:0] cur;
        logic [DATA_W+1:0] want;
        logic [ADDR_W-1:0] want_a;
        int                a;
        cur = {bus.pix_data, bus.pix_eol, bus.pix_last};
        if (rst) begin
            exp_addr.delete();
            exp_pix.delete();
            outstanding   = 0;
            prev_stall    = 1'b0;
            waiting_ready = 1'b0;
        end else begin
            if (waiting_ready && bus.hop_ready) begin
                ready_back_cyc = cyc;
                waiting_ready  = 1'b0;
            end
            if (bus.hop_valid && bus.hop_ready) begin
                acc_gap       = cyc - last_hs_cyc;
                acc_cyc       = cyc;
                acc_cnt++;
                waiting_ready = 1'b1;
                first_rd_cyc  = -1;
                first_pv_cyc  = -1;
                win_pix       = 0;
                win_eol       = 0;
                win_reads     = 0;
                first_addr    = -1;
                max_addr      = 0;
                for (int r = 0; r < int'(SWEEP_Y); r++) begin
                    for (int c = 0; c < int'(SWEEP_X); c++) begin
                        a = (int'(bus.y_hop) + r) * int'(IMG_WIDTH) + int'(bus.x_hop) + c;
                        exp_addr.push_back(ADDR_W'(a));
                        exp_pix.push_back({a[7:0], c == int'(SWEEP_X) - 1,
                                           (r == int'(SWEEP_Y) - 1) && (c == int'(SWEEP_X) - 1)});
                    end
                end
            end
            if (bus.mem_rd_en) begin
                tests_run++;
                if (exp_addr.size() == 0) begin
                    tests_failed++;
                    $display("FAIL mem_addr: got %0d, want no read", bus.mem_addr);
                end else begin
                    want_a = exp_addr.pop_front();
                    if (bus.mem_addr !== want_a) begin
                        tests_failed++;
                        $display("FAIL mem_addr: got %0d, want %0d", bus.mem_addr, want_a);
                    end
                end
                if (first_rd_cyc < 0) begin
                    first_rd_cyc = cyc;
                    first_addr   = int'(bus.mem_addr);
                end
                if (int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
                win_reads++;
                outstanding++;
            end
            if (bus.pix_valid && first_pv_cyc < 0) first_pv_cyc = cyc;
            if (prev_stall) begin
                tests_run++;
                if (!bus.pix_valid || cur !== prev_pix) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got valid=%b %h, want valid=1 %h",
                             bus.pix_valid, cur, prev_pix);
                end
            end
            if (bus.pix_valid && bus.pix_ready) begin
                tests_run++;
                if (exp_pix.size() == 0) begin
                    tests_failed++;
                    $display("FAIL pixel: got %h, want no pixel", cur);
                end else begin
                    want = exp_pix.pop_front();
                    if (cur !== want) begin
                        tests_failed++;
                        $display("FAIL pixel #%0d {data,eol,last}: got %h, want %h",
                                 win_pix + 1, cur, want);
                    end
                end
                win_pix++;
                if (bus.pix_eol) win_eol++;
                if (bus.pix_last) last_hs_cyc = cyc;
                outstanding--;
            end
            if (bus.mem_rd_en) begin
                tests_run++;
                if (outstanding > 2) begin
                    tests_failed++;
                    $display("FAIL credit: got %0d outstanding, want <= 2", outstanding);
                end
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_pix   = cur;
        end
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (exp_pix.size() == 0 && exp_addr.size() == 0 && !busy && bus.hop_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue_hop(input int x, input int y, output bit ok);
        int start;
        start = acc_cnt;
        ok    = 1'b0;
        @(posedge clk); #1;
        bus.x_hop     = W_X'(x);
        bus.y_hop     = W_Y'(y);
        bus.hop_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (acc_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.hop_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        tests_run++;
        if (bus.hop_ready !== 1'b0 || busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: got ready=%b busy=%b rd=%b, want 0 0 0",
                     bus.hop_ready, busy, bus.mem_rd_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (bus.pix_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 || busy !== 1'b0 ||
            bus.hop_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: got pv=%b rd=%b busy=%b ready=%b, want 0 0 0 1",
                     bus.pix_valid, bus.mem_rd_en, busy, bus.hop_ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        bus.pix_ready = 1'b1;
        issue_hop(0, 0, ok);
        if (ok) wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL basic_done: got timeout, want window complete");
        end
        tests_run++;
        if (first_rd_cyc - acc_cyc != 1 || first_pv_cyc - acc_cyc != 3) begin
            tests_failed++;
            $display("FAIL basic_latency: got rd@%0d pv@%0d, want rd@1 pv@3",
                     first_rd_cyc - acc_cyc, first_pv_cyc - acc_cyc);
        end
        tests_run++;
        if (last_hs_cyc - acc_cyc != NPIX + 2 || ready_back_cyc - acc_cyc != NPIX + 3) begin
            tests_failed++;
            $display("FAIL basic_end: got last@%0d ready@%0d, want last@%0d ready@%0d",
                     last_hs_cyc - acc_cyc, ready_back_cyc - acc_cyc, NPIX + 2, NPIX + 3);
        end
        tests_run++;
        if (win_pix != NPIX || win_eol != int'(SWEEP_Y) || first_addr != 0) begin
            tests_failed++;
            $display("FAIL basic_count: got pix=%0d eol=%0d first=%0d, want %0d %0d 0",
                     win_pix, win_eol, first_addr, NPIX, SWEEP_Y);
        end
    endtask

    task automatic test_max_hop();
        bit ok;
        issue_hop(16, 25, ok);
        if (ok) wait_idle(ok);
        tests_run++;
        if (!ok || first_addr != 1041 || max_addr != 2007 || win_pix != NPIX) begin
            tests_failed++;
            $display("FAIL max_hop: got ok=%b first=%0d max=%0d pix=%0d, want 1 1041 2007 %0d",
                     ok, first_addr, max_addr, win_pix, NPIX);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        bit done;
        issue_hop(5, 7, ok);
        done = 1'b0;
        for (int i = 0; i < 4000 && ok && !done; i++) begin
            @(posedge clk); #1;
            bus.pix_ready = 1'($urandom_range(0, 1));
            done = (exp_pix.size() == 0 && exp_addr.size() == 0 && !busy);
        end
        bus.pix_ready = 1'b1;
        tests_run++;
        if (!done || win_pix != NPIX) begin
            tests_failed++;
            $display("FAIL random_ready: got done=%b pix=%0d, want 1 %0d", done, win_pix, NPIX);
        end
    endtask

    task automatic test_stall_start();
        bit ok;
        @(posedge clk); #1;
        bus.pix_ready = 1'b0;
        issue_hop(0, 0, ok);
        repeat (19) @(negedge clk);
        #1;
        tests_run++;
        if (!ok || win_reads != 2 || bus.pix_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_reads: got ok=%b reads=%0d pv=%b, want 1 2 1",
                     ok, win_reads, bus.pix_valid);
        end
        @(posedge clk); #1;
        bus.pix_ready = 1'b1;
        wait_idle(ok);
        tests_run++;
        if (!ok || win_pix != NPIX) begin
            tests_failed++;
            $display("FAIL stall_resume: got ok=%b pix=%0d, want 1 %0d", ok, win_pix, NPIX);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int start;
        start = acc_cnt;
        ok    = 1'b0;
        @(posedge clk); #1;
        bus.x_hop     = W_X'(0);
        bus.y_hop     = W_Y'(0);
        bus.hop_valid = 1'b1;
        for (int i = 0; i < 100 && acc_cnt == start; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        bus.x_hop = W_X'(1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (acc_cnt == start + 2) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.hop_valid = 1'b0;
        tests_run++;
        if (!ok || acc_gap != 1) begin
            tests_failed++;
            $display("FAIL b2b_gap: got ok=%b gap=%0d, want 1 1", ok, acc_gap);
        end
        if (ok) wait_idle(ok);
        tests_run++;
        if (!ok || first_addr != 1 || win_pix != NPIX) begin
            tests_failed++;
            $display("FAIL b2b_second: got ok=%b first=%0d pix=%0d, want 1 1 %0d",
                     ok, first_addr, win_pix, NPIX);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        issue_hop(0, 0, ok);
        for (int i = 0; i < 300 && ok && win_pix < 100; i++) begin
            @(negedge clk); #1;
        end
        tests_run++;
        if (win_pix != 100) begin
            tests_failed++;
            $display("FAIL mid_count: got %0d handshakes, want 100", win_pix);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (bus.pix_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 || busy !== 1'b0 ||
            bus.hop_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: got pv=%b rd=%b busy=%b ready=%b, want 0 0 0 1",
                     bus.pix_valid, bus.mem_rd_en, busy, bus.hop_ready);
        end
        issue_hop(2, 3, ok);
        if (ok) wait_idle(ok);
        tests_run++;
        if (!ok || first_addr != 125 || win_pix != NPIX) begin
            tests_failed++;
            $display("FAIL mid_new_hop: got ok=%b first=%0d pix=%0d, want 1 125 %0d",
                     ok, first_addr, win_pix, NPIX);
        end
    endtask

    initial begin
        bus.hop_valid = 1'b0;
        bus.x_hop     = '0;
        bus.y_hop     = '0;
        bus.pix_ready = 1'b1;
        test_reset();
        test_basic();
        test_max_hop();
        test_random_ready();
        test_stall_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
